inst_fetch_queue: RTL

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit: one-outstanding-request fetch FSM feeding a circular
// instruction queue, with branch redirect flush and stale-response dropping.
module inst_fetch_queue #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] Instruction,
  output logic [63:0] PC_Out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [63:0]     fetch_pc_r;
  logic [63:0]     req_addr_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [63:0]     pc_mem_r   [DEPTH];
  logic [31:0]     inst_mem_r [DEPTH];

  logic            pop_s;
  logic            space_s;
  logic            req_s;
  logic            push_s;
  logic [63:0]     addr_s;

  // Queue handshake and free-slot test; a same-cycle pop frees a slot.
  always_comb begin
    pop_s   = (count_r != {CW{1'b0}}) && inst_ready;
    space_s = (count_r < CW'(DEPTH)) || pop_s;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (req_s && !imem_ack) begin
          // An issued request left unanswered by a redirect becomes stale.
          state_s = redirect_valid ? S_DROP : S_WAIT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          state_s = S_IDLE;
        end else if (redirect_valid) begin
          state_s = S_DROP;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DROP;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // FSM outputs: request strobe, address and push qualification.
  always_comb begin
    req_s  = 1'b0;
    addr_s = fetch_pc_r;
    case (state_r)
      S_IDLE: begin
        req_s  = space_s;
        addr_s = fetch_pc_r;
      end
      S_WAIT, S_DROP: begin
        req_s  = 1'b1;
        addr_s = req_addr_r;
      end
      default: begin
        req_s  = 1'b0;
        addr_s = fetch_pc_r;
      end
    endcase
    push_s    = req_s && imem_ack && !redirect_valid && (state_r != S_DROP);
    imem_req  = reset && req_s;
    imem_addr = addr_s;
  end

  // Fetch PC and latched request address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_r <= RESET_PC;
      req_addr_r <= RESET_PC;
    end else begin
      if (redirect_valid) begin
        fetch_pc_r <= redirect_pc;
      end else if (push_s) begin
        fetch_pc_r <= fetch_pc_r + 64'd4;
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
      if (state_r == S_IDLE) begin
        req_addr_r <= fetch_pc_r;
      end else begin
        req_addr_r <= req_addr_r;
      end
    end
  end

  // Circular queue storage, pointers and occupancy; redirect flushes all.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]   <= 64'd0;
        inst_mem_r[i] <= 32'd0;
      end
    end else if (redirect_valid) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
        inst_mem_r[wr_ptr_r] <= imem_rdata;
        wr_ptr_r             <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CW'(1);
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CW'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Head presentation, forced to zero while the queue is empty.
  always_comb begin
    inst_valid = (count_r != {CW{1'b0}});
    if (inst_valid) begin
      Instruction = inst_mem_r[rd_ptr_r];
      PC_Out      = pc_mem_r[rd_ptr_r];
    end else begin
      Instruction = 32'd0;
      PC_Out      = 64'd0;
    end
  end

endmodule
